// File: rtl/stim_scheduler.sv
// stim_scheduler: gathers one ll/ne/ps feature per window and runs a threshold majority
// vote on each complete window. A run of DETECT_COUNT positive windows fires a
// STIM_LEN-cycle pulse, followed by a REFRACT_LEN-cycle hold-off.
// Build option: define STIM_SCHED_WDOG_EN to add the partial-window watchdog
// (err_timeout). Without it, partial windows wait indefinitely and err_timeout is 0.
module stim_scheduler #(
  parameter int unsigned            LL_W         = 25,
  parameter int unsigned            FT_W         = 40,
  parameter logic signed [LL_W-1:0] LL_TH        = '0,
  parameter logic signed [FT_W-1:0] NE_TH        = '0,
  parameter logic signed [FT_W-1:0] PS_TH        = '0,
  parameter int unsigned            VOTE_MIN     = 2,
  parameter int unsigned            DETECT_COUNT = 3,
  parameter int unsigned            STIM_LEN     = 1000,
  parameter int unsigned            REFRACT_LEN  = 5000,
  parameter int unsigned            CNT_W        = 16,
  parameter int unsigned            WDOG_CYCLES  = 4096
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [LL_W-1:0] din_ll,
  input  logic [FT_W-1:0] din_ne,
  input  logic [FT_W-1:0] din_ps,
  input  logic            data_ready_ll,
  input  logic            data_ready_ne,
  input  logic            data_ready_ps,
  output logic            stimulation,
  output logic            window_done,
  output logic            detect,
  output logic [1:0]      vote_count,
  output logic            err_timeout
);

  localparam logic [1:0] VoteMin = 2'(VOTE_MIN);
  localparam logic [7:0] DetMin  = 8'(DETECT_COUNT);
  localparam longint unsigned CntMax = (64'd1 << CNT_W) - 64'd1;

  // Reject parameter sets the timers or vote logic cannot represent.
  if (VOTE_MIN < 1 || VOTE_MIN > 3 || DETECT_COUNT < 1 || DETECT_COUNT > 255 ||
      STIM_LEN < 1 || REFRACT_LEN < 1 || 64'(STIM_LEN) > CntMax ||
      64'(REFRACT_LEN) > CntMax || 64'(WDOG_CYCLES) > CntMax) begin : g_bad_cfg
    $error("stim_scheduler: invalid parameter set");
  end

  typedef enum logic [1:0] {StIdle, StStim, StRefract} state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        timer_q;
  logic [7:0]              cnt_q;
  logic                    stim_q;

  // Flag/strobe vectors are ordered {ps, ne, ll}.
  logic [2:0]              flg_q, flg_d, rdy;
  logic signed [LL_W-1:0]  val_ll_q, eff_ll;
  logic signed [FT_W-1:0]  val_ne_q, val_ps_q, eff_ne, eff_ps;
  logic                    gt_ll, gt_ne, gt_ps;
  logic [1:0]              votes;
  logic                    complete, positive, timeout;
  logic                    window_done_q, detect_q;
  logic [1:0]              vote_count_q;
  logic [7:0]              cnt_inc;

  // Capture, window completion and vote evaluation.
  always_comb begin
    rdy    = {data_ready_ps, data_ready_ne, data_ready_ll} & {3{~en}};
    // A feature whose flag is already set keeps its stored value; a strobe on it in the
    // completing cycle belongs to the next window.
    eff_ll = flg_q[0] ? val_ll_q : $signed(din_ll);
    eff_ne = flg_q[1] ? val_ne_q : $signed(din_ne);
    eff_ps = flg_q[2] ? val_ps_q : $signed(din_ps);
    gt_ll  = eff_ll > LL_TH;
    gt_ne  = eff_ne > NE_TH;
    gt_ps  = eff_ps > PS_TH;
    votes  = {1'b0, gt_ll} + {1'b0, gt_ne} + {1'b0, gt_ps};
    positive = votes >= VoteMin;
    complete = ~en & (&(flg_q | rdy));
    if (en)            flg_d = '0;
    else if (complete) flg_d = rdy & flg_q;
    else if (timeout)  flg_d = rdy;
    else               flg_d = flg_q | rdy;
    cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  end

`ifdef STIM_SCHED_WDOG_EN
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic             err_q;

  assign timeout = ~en & (|flg_q) & ~complete & (wdog_q == CNT_W'(WDOG_CYCLES - 1));

  // Watchdog counts cycles since the first strobe of the open window.
  always_comb begin
    wdog_d = '0;
    if (en)                       wdog_d = '0;
    else if (complete || timeout) wdog_d = (|flg_d) ? CNT_W'(1) : '0;
    else if (|flg_q)              wdog_d = wdog_q + CNT_W'(1);
    else if (|rdy)                wdog_d = CNT_W'(1);
  end

  // Watchdog state and registered timeout pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= timeout;
    end
  end

  assign err_timeout = err_q;
`else
  assign timeout     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Feature registers, flags and per-window status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flg_q         <= '0;
      val_ll_q      <= '0;
      val_ne_q      <= '0;
      val_ps_q      <= '0;
      window_done_q <= 1'b0;
      detect_q      <= 1'b0;
      vote_count_q  <= '0;
    end else begin
      flg_q <= flg_d;
      if (rdy[0]) val_ll_q <= $signed(din_ll);
      if (rdy[1]) val_ne_q <= $signed(din_ne);
      if (rdy[2]) val_ps_q <= $signed(din_ps);
      window_done_q <= complete;
      detect_q      <= complete & positive;
      if (complete) vote_count_q <= votes;
    end
  end

  // Trigger FSM: consecutive-positive counter, pulse timer and refractory timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      timer_q <= '0;
      cnt_q   <= '0;
      stim_q  <= 1'b0;
    end else if (en) begin
      state_q <= StIdle;
      timer_q <= '0;
      cnt_q   <= '0;
      stim_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (complete) begin
            if (!positive) begin
              cnt_q <= '0;
            end else if (cnt_inc >= DetMin) begin
              state_q <= StStim;
              cnt_q   <= '0;
              stim_q  <= 1'b1;
              timer_q <= CNT_W'(STIM_LEN - 1);
            end else begin
              cnt_q <= cnt_inc;
            end
          end else if (timeout) begin
            cnt_q <= '0;
          end
        end
        StStim: begin
          cnt_q <= '0;
          if (timer_q == '0) begin
            state_q <= StRefract;
            stim_q  <= 1'b0;
            timer_q <= CNT_W'(REFRACT_LEN - 1);
          end else begin
            timer_q <= timer_q - CNT_W'(1);
          end
        end
        StRefract: begin
          cnt_q <= '0;
          if (timer_q == '0) state_q <= StIdle;
          else               timer_q <= timer_q - CNT_W'(1);
        end
        default: begin
          state_q <= StIdle;
          stim_q  <= 1'b0;
          timer_q <= '0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign stimulation = stim_q;
  assign window_done = window_done_q;
  assign detect      = detect_q;
  assign vote_count  = vote_count_q;

endmodule

// File: tb/tb_stim_scheduler.sv
// Directed bench for stim_scheduler with default parameters (watchdog build off).
module tb_stim_scheduler;

  localparam int LL_W = 25;
  localparam int FT_W = 40;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en  = 1'b0;
  logic [LL_W-1:0] din_ll = '0;
  logic [FT_W-1:0] din_ne = '0;
  logic [FT_W-1:0] din_ps = '0;
  logic            data_ready_ll = 1'b0;
  logic            data_ready_ne = 1'b0;
  logic            data_ready_ps = 1'b0;
  logic            stimulation, window_done, detect, err_timeout;
  logic [1:0]      vote_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  stim_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .din_ll        (din_ll),
    .din_ne        (din_ne),
    .din_ps        (din_ps),
    .data_ready_ll (data_ready_ll),
    .data_ready_ne (data_ready_ne),
    .data_ready_ps (data_ready_ps),
    .stimulation   (stimulation),
    .window_done   (window_done),
    .detect        (detect),
    .vote_count    (vote_count),
    .err_timeout   (err_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Strobe the features selected by m ({ps, ne, ll}) for one cycle; returns one cycle
  // later, where the registered window outputs for that cycle are visible.
  task automatic drive(input logic [2:0] m, input int ll, input int ne, input int ps);
    din_ll        = LL_W'(ll);
    din_ne        = FT_W'(ne);
    din_ps        = FT_W'(ps);
    data_ready_ll = m[0];
    data_ready_ne = m[1];
    data_ready_ps = m[2];
    step();
    data_ready_ll = 1'b0;
    data_ready_ne = 1'b0;
    data_ready_ps = 1'b0;
  endtask

  initial begin
    int hi, last_hi, ndet, idx, errs, wds;

    // Reset state
    #2;
    check("rst_stim", stimulation, 0);
    check("rst_wdone", window_done, 0);
    check("rst_detect", detect, 0);
    check("rst_votes", vote_count, 0);
    check("rst_err", err_timeout, 0);
    step();
    rst = 1'b0;
    step();

    // One window per cycle, all negative
    for (int i = 0; i < 3; i++) begin
      drive(3'b111, -1, -1, -1);
      check("thru_wdone", window_done, 1);
      check("thru_votes", vote_count, 0);
    end
    step();
    check("thru_idle", window_done, 0);

    // Three positive windows trigger; pulse and refractory with windows every 10 cycles
    for (int w = 0; w < 3; w++) begin
      drive(3'b111, 5, 7, -3);
      check("pos_wdone", window_done, 1);
      check("pos_detect", detect, 1);
      check("pos_votes", vote_count, 2);
      check("pos_stim", stimulation, (w == 2) ? 1 : 0);
    end
    hi = 1; last_hi = 1; ndet = 0; idx = 1;
    for (int i = 0; i < 600; i++) begin
      drive(3'b111, 5, 7, -3);
      idx++;
      ndet += int'(detect);
      if (stimulation) begin hi++; last_hi = idx; end
      for (int j = 0; j < 9; j++) begin
        step();
        idx++;
        if (stimulation) begin hi++; last_hi = idx; end
      end
    end
    check("stim_len", hi, 1000);
    check("stim_last_cycle", last_hi, 1000);
    check("hold_detects", ndet, 600);
    check("hold_end_stim", stimulation, 0);

    // After refractory, three fresh positives are needed
    drive(3'b111, 5, 7, -3);
    check("retrig_1", stimulation, 0);
    drive(3'b111, 5, 7, -3);
    check("retrig_2", stimulation, 0);
    drive(3'b111, 5, 7, -3);
    check("retrig_3", stimulation, 1);

    // Disable mid-pulse: pulse truncated, strobes ignored, no refractory
    en = 1'b1;
    drive(3'b111, 5, 7, -3);
    check("en_stim", stimulation, 0);
    check("en_wdone", window_done, 0);
    en = 1'b0;
    drive(3'b111, 5, 7, -3);
    drive(3'b111, 5, 7, -3);
    check("abort_no_early", stimulation, 0);
    drive(3'b111, 5, 7, -3);
    check("abort_no_refract", stimulation, 1);
    en = 1'b1;
    step();
    en = 1'b0;

    // Negative window clears the consecutive counter
    drive(3'b111, 5, 7, -3);
    check("clr_p1", detect, 1);
    drive(3'b111, -1, -1, -3);
    check("clr_neg_detect", detect, 0);
    check("clr_neg_votes", vote_count, 0);
    drive(3'b111, 5, 7, -3);
    drive(3'b111, 5, 7, -3);
    check("clr_no_trig", stimulation, 0);
    drive(3'b111, 5, 7, -3);
    check("clr_trig", stimulation, 1);
    en = 1'b1;
    step();
    en = 1'b0;

    // Skewed strobes: ll t, ll=-9 t+2, ne t+3, ps+ll t+5
    drive(3'b001, 5, 0, 0);
    step();
    drive(3'b001, -9, 0, 0);
    check("skew_open", window_done, 0);
    drive(3'b010, 0, 7, 0);
    step();
    drive(3'b101, 5, 0, -3);
    check("skew_wdone", window_done, 1);
    check("skew_votes", vote_count, 1);
    check("skew_detect", detect, 0);
    drive(3'b110, 0, 7, 4);
    check("skew_next_wdone", window_done, 1);
    check("skew_next_votes", vote_count, 3);

    // Partial window waits indefinitely with no timeout pulse
    drive(3'b011, 5, 7, 0);
    errs = 0; wds = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      errs += int'(err_timeout);
      wds  += int'(window_done);
    end
    check("part_no_err", errs, 0);
    check("part_no_wdone", wds, 0);
    drive(3'b100, 0, 0, -3);
    check("part_wdone", window_done, 1);
    check("part_votes", vote_count, 2);
    check("part_stim", stimulation, 0);

    // Async reset at pulse cycle 10
    drive(3'b111, 5, 7, -3);
    check("rst_mid_rise", stimulation, 1);
    repeat (9) step();
    check("rst_mid_c10", stimulation, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_stim", stimulation, 0);
    check("rst_mid_votes", vote_count, 0);
    check("rst_mid_detect", detect, 0);
    step();
    rst = 1'b0;
    drive(3'b111, 5, 7, -3);
    check("post_rst_detect", detect, 1);
    check("post_rst_idle", stimulation, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
